// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory port arbiter: FSM state encoding and
// transaction owner codes.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_BUSY_FETCH = 2'd1,
    ST_BUSY_DATA  = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_DATA  = 2'd2
  } owner_e;

  // Owner of the memory port is implied by the busy state.
  function automatic owner_e owner_of(input arb_state_e st);
    owner_e own;
    case (st)
      ST_BUSY_FETCH: own = OWN_FETCH;
      ST_BUSY_DATA:  own = OWN_DATA;
      default:       own = OWN_NONE;
    endcase
    return own;
  endfunction

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// Saturating count of data grants made while fetch was waiting; at_limit forces
// the next contested grant to fetch.
module mem_arb_starve_cnt #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam int CW = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(LIMIT);
  localparam logic [CW-1:0] ONE = CW'(1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign at_limit = (cnt_q == LIM);

  // Clear has priority; increment holds once the limit is reached.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !at_limit) begin
      cnt_d = cnt_q + ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between fetch (read only) and data (load/store),
// one transaction at a time, data-first with a fetch starvation guard and fetch flush.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int ADDR_SIZE    = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 fetch_readEn,
  input  logic [ADDR_SIZE-1:0] fetch_addr,
  output logic                 fetch_readFin,
  output logic [XLEN-1:0]      fetch_rdata,
  input  logic                 data_readEn,
  input  logic                 data_writeEn,
  input  logic [ADDR_SIZE-1:0] data_addr,
  input  logic [XLEN-1:0]      data_wdata,
  input  logic [XLEN/8-1:0]    data_wmask,
  output logic                 data_fin,
  output logic [XLEN-1:0]      data_rdata,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [XLEN-1:0]      mem_wdata,
  output logic [XLEN/8-1:0]    mem_wmask,
  input  logic                 mem_ack,
  input  logic [XLEN-1:0]      mem_rdata
);

  localparam int MW = XLEN / 8;

  arb_state_e           state_q, state_d;
  logic                 drop_q, drop_d;
  logic                 mem_req_q, mem_req_d;
  logic                 mem_we_q, mem_we_d;
  logic [ADDR_SIZE-1:0] mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]      mem_wdata_q, mem_wdata_d;
  logic [MW-1:0]        mem_wmask_q, mem_wmask_d;

  logic   fetch_req_eff;
  logic   data_req;
  logic   at_limit;
  logic   grant_data;
  logic   grant_fetch;
  logic   starve_inc;
  logic   starve_clr;
  owner_e owner;

  assign fetch_req_eff = fetch_readEn & ~flush;
  assign data_req      = data_readEn | data_writeEn;
  assign grant_data    = (state_q == ST_IDLE) & data_req & (~fetch_req_eff | ~at_limit);
  assign grant_fetch   = (state_q == ST_IDLE) & fetch_req_eff & (~data_req | at_limit);
  assign starve_inc    = grant_data & fetch_req_eff;
  assign starve_clr    = grant_fetch | ((grant_data | grant_fetch) & ~fetch_readEn);
  assign owner         = owner_of(state_q);

  // A flush landing on the ack cycle also kills the fetch result.
  assign fetch_readFin = mem_ack & (owner == OWN_FETCH) & ~drop_q & ~flush;
  assign data_fin      = mem_ack & (owner == OWN_DATA);
  assign fetch_rdata   = mem_rdata;
  assign data_rdata    = mem_rdata;

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wmask = mem_wmask_q;

  mem_arb_starve_cnt #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clk      (clk),
    .rst      (rst),
    .inc      (starve_inc),
    .clr      (starve_clr),
    .at_limit (at_limit)
  );

  // Next-state and memory-port latch logic.
  always_comb begin
    state_d     = state_q;
    drop_d      = drop_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wmask_d = mem_wmask_q;
    case (state_q)
      ST_IDLE: begin
        drop_d = 1'b0;
        if (grant_data) begin
          state_d     = ST_BUSY_DATA;
          mem_req_d   = 1'b1;
          mem_we_d    = data_writeEn;
          mem_addr_d  = data_addr;
          mem_wdata_d = data_wdata;
          mem_wmask_d = data_writeEn ? data_wmask : '0;
        end else if (grant_fetch) begin
          state_d     = ST_BUSY_FETCH;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = fetch_addr;
          mem_wdata_d = '0;
          mem_wmask_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY_FETCH: begin
        if (mem_ack) begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
          drop_d    = 1'b0;
        end else begin
          drop_d = drop_q | flush;
        end
      end
      ST_BUSY_DATA: begin
        if (mem_ack) begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
        end else begin
          state_d = ST_BUSY_DATA;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
        drop_d    = 1'b0;
      end
    endcase
  end

  // State and registered memory-port outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      drop_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
    end else begin
      state_q     <= state_d;
      drop_q      <= drop_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wmask_q <= mem_wmask_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected grants and finish strobes are queued by
// the stimulus and checked by a forked monitor as the DUT presents them.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        fetch_readEn = 1'b0;
  logic [31:0] fetch_addr = 32'h0;
  logic        fetch_readFin;
  logic [31:0] fetch_rdata;
  logic        data_readEn = 1'b0;
  logic        data_writeEn = 1'b0;
  logic [31:0] data_addr = 32'h0;
  logic [31:0] data_wdata = 32'h0;
  logic [3:0]  data_wmask = 4'h0;
  logic        data_fin;
  logic [31:0] data_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.XLEN(32), .ADDR_SIZE(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .fetch_readEn(fetch_readEn), .fetch_addr(fetch_addr),
    .fetch_readFin(fetch_readFin), .fetch_rdata(fetch_rdata),
    .data_readEn(data_readEn), .data_writeEn(data_writeEn), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_wmask(data_wmask),
    .data_fin(data_fin), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } grant_t;

  typedef struct packed {
    logic        is_fetch;
    logic [31:0] rdata;
  } fin_t;

  grant_t grant_q[$];
  fin_t   fin_q[$];
  int     vectors = 0;
  int     miscompares = 0;
  int     fin_total = 0;
  int     lat = 0;
  int     lat_cnt = 0;
  bit     mem_auto = 1'b0;
  bit     data_persist = 1'b0;
  bit     last_f = 1'b0;

  // Memory read data pattern: address with the top half xor'ed by 0xC0DE.
  function automatic logic [31:0] rd_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic exp_grant(input logic we, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] wm);
    grant_t g;
    g.we = we; g.addr = a; g.wdata = wd; g.wmask = wm;
    grant_q.push_back(g);
  endtask

  task automatic exp_fin(input logic is_f, input logic [31:0] a);
    fin_t f;
    f.is_fetch = is_f; f.rdata = rd_of(a);
    fin_q.push_back(f);
  endtask

  task automatic monitor();
    logic   prev_req;
    grant_t g;
    fin_t   f;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_req = 1'b0;
      end else begin
        if (mem_req && !prev_req) begin
          if (grant_q.size() == 0) begin
            check("grant_unexpected", {mem_we, mem_addr[30:0]}, 32'hFFFF_FFFF);
          end else begin
            g = grant_q.pop_front();
            check("grant_addr", mem_addr, g.addr);
            check("grant_we", {31'h0, mem_we}, {31'h0, g.we});
            check("grant_wmask", {28'h0, mem_wmask}, {28'h0, g.wmask});
            if (g.we) check("grant_wdata", mem_wdata, g.wdata);
          end
        end
        if (fetch_readFin || data_fin) begin
          fin_total++;
          if (fin_q.size() == 0) begin
            check("fin_unexpected", {30'h0, fetch_readFin, data_fin}, 32'h0);
          end else begin
            f = fin_q.pop_front();
            check("fin_fetch", {30'h0, fetch_readFin, data_fin}, {30'h0, f.is_fetch, ~f.is_fetch});
            check("fin_rdata", f.is_fetch ? fetch_rdata : data_rdata, f.rdata);
          end
        end
        prev_req = mem_req;
      end
    end
  endtask

  // One clock: requesters drop on their fin, memory model acks after 'lat' busy cycles.
  task automatic step();
    logic f, d, ack_was;
    @(negedge clk);
    f = fetch_readFin;
    d = data_fin;
    @(posedge clk);
    #1;
    ack_was = mem_ack;
    mem_ack = 1'b0;
    last_f  = f;
    if (f) fetch_readEn = 1'b0;
    if (d && !data_persist) begin
      data_readEn  = 1'b0;
      data_writeEn = 1'b0;
    end
    if (mem_auto && mem_req && !ack_was) begin
      if (lat_cnt == lat) begin
        mem_ack   = 1'b1;
        mem_rdata = rd_of(mem_addr);
        lat_cnt   = 0;
      end else begin
        lat_cnt++;
      end
    end else if (!mem_req) begin
      lat_cnt = 0;
    end
  endtask

  task automatic run_idle(input int max);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while ((mem_req || mem_ack || fetch_readEn || data_readEn || data_writeEn) && n < max);
    if (n >= max) check("idle_timeout", n, 32'h0);
  endtask

  int fin_snap;
  int n;
  bit cnt_checked;

  initial begin
    fork
      monitor();
    join_none

    // Reset state and ack ignored in IDLE.
    #12;
    check("rst_req", {31'h0, mem_req}, 32'h0);
    check("rst_we", {31'h0, mem_we}, 32'h0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_wdata", mem_wdata, 32'h0);
    check("rst_wmask", {28'h0, mem_wmask}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    mem_ack = 1'b1;
    #1;
    check("idle_ack_fin", {30'h0, fetch_readFin, data_fin}, 32'h0);
    @(posedge clk); #1;
    mem_ack = 1'b0;
    check("idle_ack_noreq", {31'h0, mem_req}, 32'h0);
    mem_auto = 1'b1;

    // 1: fetch only, ack 3 cycles after mem_req.
    fetch_readEn = 1'b1; fetch_addr = 32'h100; lat = 3;
    exp_grant(1'b0, 32'h100, 32'h0, 4'h0);
    exp_fin(1'b1, 32'h100);
    step();
    check("t1_req", {31'h0, mem_req}, 32'h1);
    step(); step();
    check("t1_nofin_early", {31'h0, fetch_readFin}, 32'h0);
    step(); #1;
    check("t1_fin", {31'h0, fetch_readFin}, 32'h1);
    run_idle(20);

    // 2: store and fetch together, data first.
    lat = 1;
    fetch_readEn = 1'b1; fetch_addr = 32'h104;
    data_writeEn = 1'b1; data_addr = 32'h200; data_wdata = 32'hDEADBEEF; data_wmask = 4'hF;
    exp_grant(1'b1, 32'h200, 32'hDEADBEEF, 4'hF);
    exp_grant(1'b0, 32'h104, 32'h0, 4'h0);
    exp_fin(1'b0, 32'h200);
    exp_fin(1'b1, 32'h104);
    run_idle(30);

    // 3: continuous loads starve fetch for exactly 4 grants.
    data_persist = 1'b1;
    data_readEn = 1'b1; data_addr = 32'h400; data_wdata = 32'h0; data_wmask = 4'h0;
    fetch_readEn = 1'b1; fetch_addr = 32'h108;
    for (int i = 0; i < 4; i++) begin
      exp_grant(1'b0, 32'h400, 32'h0, 4'h0);
      exp_fin(1'b0, 32'h400);
    end
    exp_grant(1'b0, 32'h108, 32'h0, 4'h0);
    exp_fin(1'b1, 32'h108);
    exp_grant(1'b0, 32'h400, 32'h0, 4'h0);
    exp_fin(1'b0, 32'h400);
    n = 0;
    cnt_checked = 1'b0;
    do begin
      step();
      n++;
      if (!cnt_checked && mem_req && mem_addr == 32'h108) begin
        check("t3_cnt_cleared", {29'h0, dut.u_starve.cnt_q}, 32'h0);
        cnt_checked = 1'b1;
      end
    end while (!last_f && n < 100);
    if (n >= 100) check("t3_timeout", n, 32'h0);
    data_persist = 1'b0;
    run_idle(30);

    // Flush in IDLE blocks the fetch grant for that cycle.
    fetch_readEn = 1'b1; fetch_addr = 32'h10C; flush = 1'b1; lat = 0;
    exp_grant(1'b0, 32'h10C, 32'h0, 4'h0);
    exp_fin(1'b1, 32'h10C);
    step();
    check("idle_flush_block", {31'h0, mem_req}, 32'h0);
    flush = 1'b0;
    step();
    check("idle_flush_release", {31'h0, mem_req}, 32'h1);
    run_idle(20);

    // 4: flush during BUSY_FETCH drops the result, then a redirected fetch completes.
    fin_snap = fin_total;
    fetch_readEn = 1'b1; fetch_addr = 32'h180; lat = 4;
    exp_grant(1'b0, 32'h180, 32'h0, 4'h0);
    step(); step();
    flush = 1'b1; fetch_readEn = 1'b0;
    step();
    flush = 1'b0;
    run_idle(20);
    check("t4_no_fin", fin_total, fin_snap);
    check("t4_req_clear", {31'h0, mem_req}, 32'h0);
    fetch_readEn = 1'b1; fetch_addr = 32'h300; lat = 1;
    exp_grant(1'b0, 32'h300, 32'h0, 4'h0);
    exp_fin(1'b1, 32'h300);
    run_idle(20);

    // Flush on the same cycle as the fetch ack.
    fin_snap = fin_total;
    fetch_readEn = 1'b1; fetch_addr = 32'h1C0; lat = 2;
    exp_grant(1'b0, 32'h1C0, 32'h0, 4'h0);
    n = 0;
    do begin
      step();
      n++;
    end while (!mem_ack && n < 20);
    flush = 1'b1; fetch_readEn = 1'b0;
    #1;
    check("ack_flush_fin", {31'h0, fetch_readFin}, 32'h0);
    step();
    flush = 1'b0;
    run_idle(20);
    check("ack_flush_no_fin", fin_total, fin_snap);

    // 5: read and write both high is a store; zero-latency ack gives fin at T+1.
    data_readEn = 1'b1; data_writeEn = 1'b1; data_addr = 32'h40;
    data_wdata = 32'h1234_5678; data_wmask = 4'h6; lat = 0;
    exp_grant(1'b1, 32'h40, 32'h1234_5678, 4'h6);
    exp_fin(1'b0, 32'h40);
    fin_snap = fin_total;
    step(); #1;
    check("t5_fin_t1", {31'h0, data_fin}, 32'h1);
    run_idle(20);
    check("t5_single_fin", fin_total, fin_snap + 1);

    // 6: async reset mid BUSY_DATA, then a stale ack.
    data_writeEn = 1'b1; data_addr = 32'h500; data_wdata = 32'hCAFEF00D; data_wmask = 4'h3;
    lat = 10;
    exp_grant(1'b1, 32'h500, 32'hCAFEF00D, 4'h3);
    step(); step();
    #2;
    rst = 1'b0;
    #1;
    check("t6_req_async", {31'h0, mem_req}, 32'h0);
    check("t6_we_async", {31'h0, mem_we}, 32'h0);
    check("t6_addr_async", mem_addr, 32'h0);
    mem_auto = 1'b0; lat_cnt = 0;
    data_writeEn = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    fin_snap = fin_total;
    @(posedge clk); #1;
    mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
    #1;
    check("t6_stale_ack", {30'h0, fetch_readFin, data_fin}, 32'h0);
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(posedge clk); #1;
    check("t6_no_fin", fin_total, fin_snap);

    check("grant_q_empty", grant_q.size(), 32'h0);
    check("fin_q_empty", fin_q.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
